fetch_stage: RTL and testbench

//  Instruction-fetch stage that feeds the decode stage through the IF_ID_pc / IF_ID_inst pipeline registers.

---
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: in-order req/gnt/rvalid fetch into a small prefetch FIFO,
// presented to decode through the IF_ID_pc / IF_ID_inst pipeline registers.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        HLT,
    input  logic        IHLT,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // Handshake: a request is accepted in any cycle with IMEM_REQ && IMEM_GNT;
    // IMEM_ADDR holds while IMEM_REQ && !IMEM_GNT. Each IMEM_RVALID retires the
    // oldest accepted request, never in the same cycle as its grant.

    logic          running;
    logic [31:0]   fpc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;

    logic [31:0]   pcq [FIFO_DEPTH];
    logic [AW-1:0] pcq_wr;
    logic [AW-1:0] pcq_rd;
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [AW-1:0] fifo_wr;
    logic [AW-1:0] fifo_rd;

    logic grant;
    logic resp;
    logic resp_live;
    logic advance_ok;
    logic pop;
    logic bypass;
    logic push;

    // running keeps IMEM_REQ low during reset and in the cycle RESn rises.
    assign occupancy  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign IMEM_REQ   = running && !REDIRECT && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign IMEM_ADDR  = fpc;
    assign grant      = IMEM_REQ && IMEM_GNT;
    assign resp       = IMEM_RVALID && (outstanding != '0);
    assign resp_live  = resp && (discard == '0) && !REDIRECT;
    assign advance_ok = !REDIRECT && !HLT && !IHLT;
    assign pop        = advance_ok && (fifo_count != '0);
    assign bypass     = advance_ok && (fifo_count == '0) && resp_live;
    assign push       = resp_live && !bypass;

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            running     <= 1'b0;
            fpc         <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
        end else begin
            running     <= 1'b1;
            outstanding <= outstanding + CW'(grant) - CW'(resp);
            if (grant)
                pcq_wr <= pcq_wr + AW'(1);
            if (resp)
                pcq_rd <= pcq_rd + AW'(1);
            if (REDIRECT) begin
                fpc     <= REDIRECT_PC & ~32'h3;
                discard <= outstanding - CW'(resp);
            end else begin
                if (grant)
                    fpc <= fpc + 32'd4;
                if (resp && (discard != '0))
                    discard <= discard - CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_count <= '0;
        end else if (REDIRECT) begin
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                fifo_wr <= fifo_wr + AW'(1);
            if (pop)
                fifo_rd <= fifo_rd + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (grant)
            pcq[pcq_wr] <= fpc;
        if (push) begin
            fifo_pc[fifo_wr]   <= pcq[pcq_rd];
            fifo_inst[fifo_wr] <= IMEM_RDATA;
        end
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            IF_ID_pc   <= RESET_PC;
            IF_ID_inst <= '0;
        end else if (REDIRECT) begin
            IF_ID_inst <= '0;
        end else if (HLT) begin
            IF_ID_inst <= IF_ID_inst;
        end else if (IHLT) begin
            IF_ID_inst <= '0;
        end else if (fifo_count != '0) begin
            IF_ID_pc   <= fifo_pc[fifo_rd];
            IF_ID_inst <= fifo_inst[fifo_rd];
        end else if (resp_live) begin
            IF_ID_pc   <= pcq[pcq_rd];
            IF_ID_inst <= IMEM_RDATA;
        end else begin
            IF_ID_inst <= '0;
        end
    end

    rvalid_needs_outstanding: assert property (
        @(posedge CLK) disable iff (!RESn) IMEM_RVALID |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue-level model of the fetch stream and
// an in-order instruction memory whose words are pc ^ 32'h13.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        CLK;
    logic        RESn;
    logic        HLT;
    logic        IHLT;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;

    fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESn(RESn), .HLT(HLT), .IHLT(IHLT),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- memory and reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic        drop;
    } flight_t;

    logic [31:0] mem_q[$];      // addresses accepted by memory, awaiting response
    flight_t     inflight[$];   // model: requests the fetch stage expects back
    logic [63:0] exp_q[$];      // model: buffered {pc, inst} awaiting decode
    logic [31:0] m_fpc;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_req;
    logic        warm;
    int          errors;
    int          checks;

    task automatic model_reset();
        mem_q.delete();
        inflight.delete();
        exp_q.delete();
        m_fpc  = RESET_PC;
        m_pc   = RESET_PC;
        m_inst = 32'h0;
        m_req  = 1'b0;
        warm   = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic set_inputs(input bit hlt, input bit ihlt, input bit redir,
                              input logic [31:0] rpc, input bit gnt, input bit mem_go);
        HLT         = hlt;
        IHLT        = ihlt;
        REDIRECT    = redir;
        REDIRECT_PC = rpc;
        IMEM_GNT    = gnt;
        IMEM_RVALID = mem_go && (mem_q.size() > 0);
        IMEM_RDATA  = IMEM_RVALID ? (mem_q[0] ^ 32'h13) : $urandom();
        m_req = warm && !redir && ((inflight.size() + exp_q.size()) < DEPTH);
    endtask

    task automatic advance();
        logic        grant;
        logic        live;
        logic [63:0] pair;
        flight_t     f;
        logic        dut_grant;
        logic [31:0] dut_addr;
        dut_grant = IMEM_REQ && IMEM_GNT;
        dut_addr  = IMEM_ADDR;
        grant = m_req && IMEM_GNT;
        live  = 1'b0;
        pair  = '0;
        if (IMEM_RVALID && inflight.size() > 0) begin
            f    = inflight.pop_front();
            live = !f.drop && !REDIRECT;
            pair = {f.pc, f.pc ^ 32'h13};
        end
        if (REDIRECT) begin
            m_inst = 32'h0;
        end else if (HLT) begin
            if (live) exp_q.push_back(pair);
        end else if (IHLT) begin
            m_inst = 32'h0;
            if (live) exp_q.push_back(pair);
        end else if (exp_q.size() > 0) begin
            {m_pc, m_inst} = exp_q.pop_front();
            if (live) exp_q.push_back(pair);
        end else if (live) begin
            {m_pc, m_inst} = pair;
        end else begin
            m_inst = 32'h0;
        end
        if (REDIRECT) begin
            exp_q.delete();
            foreach (inflight[i]) inflight[i].drop = 1'b1;
            m_fpc = REDIRECT_PC & ~32'h3;
        end
        if (grant) begin
            inflight.push_back({m_fpc, 1'b0});
            m_fpc = m_fpc + 32'd4;
        end
        warm = 1'b1;
        if (IMEM_RVALID) void'(mem_q.pop_front());
        if (dut_grant) mem_q.push_back(dut_addr);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        checks++;
        if (IMEM_REQ !== 1'b0) begin
            errors++; $display("FAIL reset_req: got %b want 0", IMEM_REQ);
        end
        checks++;
        if (IF_ID_pc !== RESET_PC) begin
            errors++; $display("FAIL reset_pc: got %h want %h", IF_ID_pc, RESET_PC);
        end
        checks++;
        if (IF_ID_inst !== 32'h0) begin
            errors++; $display("FAIL reset_inst: got %h want 0", IF_ID_inst);
        end
        @(negedge CLK);
        @(negedge CLK);
        RESn = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 20; i++) begin
            set_inputs(0, 0, 0, 32'h0, 1, 1);
            #1;
            checks++;
            if ({IMEM_REQ, IMEM_ADDR, IF_ID_pc, IF_ID_inst} !== {m_req, m_fpc, m_pc, m_inst}) begin
                errors++;
                $display("FAIL stream[%0d]: got req=%b addr=%h pc=%h inst=%h want req=%b addr=%h pc=%h inst=%h",
                         i, IMEM_REQ, IMEM_ADDR, IF_ID_pc, IF_ID_inst, m_req, m_fpc, m_pc, m_inst);
            end
            advance();
        end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 16; i++) begin
            set_inputs((i >= 3 && i < 7), 0, 0, 32'h0, 1, 1);
            #1;
            checks++;
            if ({IMEM_REQ, IMEM_ADDR, IF_ID_pc, IF_ID_inst} !== {m_req, m_fpc, m_pc, m_inst}) begin
                errors++;
                $display("FAIL halt[%0d]: got req=%b addr=%h pc=%h inst=%h want req=%b addr=%h pc=%h inst=%h",
                         i, IMEM_REQ, IMEM_ADDR, IF_ID_pc, IF_ID_inst, m_req, m_fpc, m_pc, m_inst);
            end
            advance();
        end
    endtask

    task automatic test_redirect();
        bit redir;
        bit go;
        for (int i = 0; i < 18; i++) begin
            redir = (i == 2) || (i == 11) || (i == 12);
            go    = !(i < 3 || i == 10 || i == 11);
            set_inputs(0, 0, redir, (i == 2) ? 32'h100 : 32'h203 + 32'(i), 1, go);
            #1;
            checks++;
            if ({IMEM_REQ, IMEM_ADDR, IF_ID_pc, IF_ID_inst} !== {m_req, m_fpc, m_pc, m_inst}) begin
                errors++;
                $display("FAIL redirect[%0d]: got req=%b addr=%h pc=%h inst=%h want req=%b addr=%h pc=%h inst=%h",
                         i, IMEM_REQ, IMEM_ADDR, IF_ID_pc, IF_ID_inst, m_req, m_fpc, m_pc, m_inst);
            end
            advance();
        end
    endtask

    task automatic test_gnt_stall();
        for (int i = 0; i < 12; i++) begin
            set_inputs(0, 0, 0, 32'h0, !(i >= 2 && i < 5), 1);
            #1;
            checks++;
            if ({IMEM_REQ, IMEM_ADDR, IF_ID_pc, IF_ID_inst} !== {m_req, m_fpc, m_pc, m_inst}) begin
                errors++;
                $display("FAIL gnt_stall[%0d]: got req=%b addr=%h pc=%h inst=%h want req=%b addr=%h pc=%h inst=%h",
                         i, IMEM_REQ, IMEM_ADDR, IF_ID_pc, IF_ID_inst, m_req, m_fpc, m_pc, m_inst);
            end
            advance();
        end
    endtask

    task automatic test_ihlt();
        for (int i = 0; i < 8; i++) begin
            set_inputs(0, (i == 2), 0, 32'h0, 1, 1);
            #1;
            checks++;
            if ({IMEM_REQ, IMEM_ADDR, IF_ID_pc, IF_ID_inst} !== {m_req, m_fpc, m_pc, m_inst}) begin
                errors++;
                $display("FAIL ihlt[%0d]: got req=%b addr=%h pc=%h inst=%h want req=%b addr=%h pc=%h inst=%h",
                         i, IMEM_REQ, IMEM_ADDR, IF_ID_pc, IF_ID_inst, m_req, m_fpc, m_pc, m_inst);
            end
            advance();
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            set_inputs(0, 0, 0, 32'h0, 1, 0);
            advance();
        end
        #2;
        RESn = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({IMEM_REQ, IF_ID_pc, IF_ID_inst} !== {1'b0, RESET_PC, 32'h0}) begin
            errors++;
            $display("FAIL reset_async: got req=%b pc=%h inst=%h want req=0 pc=%h inst=0",
                     IMEM_REQ, IF_ID_pc, IF_ID_inst, RESET_PC);
        end
        IMEM_RVALID = 1'b1;
        IMEM_RDATA  = 32'hDEAD_BEEF;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({IMEM_REQ, IF_ID_pc, IF_ID_inst} !== {1'b0, RESET_PC, 32'h0}) begin
            errors++;
            $display("FAIL reset_stale: got req=%b pc=%h inst=%h want req=0 pc=%h inst=0",
                     IMEM_REQ, IF_ID_pc, IF_ID_inst, RESET_PC);
        end
        IMEM_RVALID = 1'b0;
        RESn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_inputs(0, 0, 0, 32'h0, 1, 1);
            #1;
            checks++;
            if ({IMEM_REQ, IMEM_ADDR, IF_ID_pc, IF_ID_inst} !== {m_req, m_fpc, m_pc, m_inst}) begin
                errors++;
                $display("FAIL restart[%0d]: got req=%b addr=%h pc=%h inst=%h want req=%b addr=%h pc=%h inst=%h",
                         i, IMEM_REQ, IMEM_ADDR, IF_ID_pc, IF_ID_inst, m_req, m_fpc, m_pc, m_inst);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_inputs($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 15) == 0, $urandom(),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            #1;
            checks++;
            if ({IMEM_REQ, IMEM_ADDR, IF_ID_pc, IF_ID_inst} !== {m_req, m_fpc, m_pc, m_inst}) begin
                errors++;
                $display("FAIL random[%0d]: got req=%b addr=%h pc=%h inst=%h want req=%b addr=%h pc=%h inst=%h",
                         i, IMEM_REQ, IMEM_ADDR, IF_ID_pc, IF_ID_inst, m_req, m_fpc, m_pc, m_inst);
            end
            advance();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        errors      = 0;
        checks      = 0;
        RESn        = 1'b0;
        HLT         = 1'b0;
        IHLT        = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 32'h0;
        IMEM_GNT    = 1'b0;
        IMEM_RVALID = 1'b0;
        IMEM_RDATA  = 32'h0;
        model_reset();
        test_reset();
        test_stream();
        test_halt();
        test_redirect();
        test_gnt_stall();
        test_ihlt();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
